// File: rtl/ame_pkg.sv
// ame_pkg: shared types, constants and helpers for the AME number restore block.
package ame_pkg;
    typedef enum logic [1:0] {AME_RST_IDLE, AME_RST_SCAN} ame_rst_state_t;
    localparam int AME_GRP_BITS = 8;
    function automatic logic [63:0] ame_sat_max(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction
endpackage

// File: rtl/ame_pri_enc_8b.sv
// ame_pri_enc_8b: combinational MSB-first priority encoder over one 8-bit group.
module ame_pri_enc_8b (
    input  logic [7:0] d,
    output logic [2:0] idx,
    output logic       vld
);
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) idx = d[i] ? 3'(i) : idx;
        vld = |d;
    end
endmodule

// File: rtl/ame_num_restore.sv
// ame_num_restore: recovers exponent and signed value from a one-hot approximated magnitude.
// Optional one-hot violation flag enabled by AME_NUM_RESTORE_ONEHOT_CHK_EN.
module ame_num_restore
    import ame_pkg::*;
#(
    parameter int COMP_DATA_BITS = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              comp_init_i,
    input  logic [COMP_DATA_BITS-1:0]         comp_data_i,
    input  logic                              comp_data_sign_i,
    output logic                              comp_busy_o,
    output logic                              comp_done_o,
    output logic [COMP_DATA_BITS-1:0]         comp_data_o,
    output logic [$clog2(COMP_DATA_BITS)-1:0] comp_shift_o,
    output logic                              comp_zero_o,
    output logic                              comp_err_o
);
    localparam int NUM_GRP    = COMP_DATA_BITS / AME_GRP_BITS;
    localparam int SHIFT_BITS = $clog2(COMP_DATA_BITS);
    localparam int GRP_W      = $clog2(NUM_GRP);

    ame_rst_state_t            state;
    logic [GRP_W-1:0]          grp;
    logic [COMP_DATA_BITS-1:0] data_q;
    logic                      sign_q;
    logic [7:0]                grp_data;
    logic [2:0]                idx;
    logic                      vld;
    logic [SHIFT_BITS-1:0]     hit_shift;
    logic [COMP_DATA_BITS-1:0] mag;
    logic [COMP_DATA_BITS-1:0] res;
    logic                      accept;
    logic                      scan_end;

    ame_pri_enc_8b u_enc (.d(grp_data), .idx(idx), .vld(vld));

    always_comb begin
        grp_data  = 8'(data_q >> {grp, 3'b000});
        hit_shift = SHIFT_BITS'({grp, idx});
        mag       = COMP_DATA_BITS'(1) << hit_shift;
        // Positive full-scale cannot be represented, so clamp to the largest positive value.
        res       = sign_q ? -mag
                  : (hit_shift == SHIFT_BITS'(COMP_DATA_BITS - 1)) ? COMP_DATA_BITS'(ame_sat_max(COMP_DATA_BITS))
                  : mag;
        accept    = state == AME_RST_IDLE && comp_init_i;
        scan_end  = state == AME_RST_SCAN && (vld || grp == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= AME_RST_IDLE;
            grp          <= '0;
            data_q       <= '0;
            sign_q       <= 1'b0;
            comp_busy_o  <= 1'b0;
            comp_done_o  <= 1'b0;
            comp_data_o  <= '0;
            comp_shift_o <= '0;
            comp_zero_o  <= 1'b0;
        end else begin
            comp_done_o <= 1'b0;
            if (accept) begin
                data_q       <= comp_data_i;
                sign_q       <= comp_data_sign_i;
                grp          <= GRP_W'(NUM_GRP - 1);
                state        <= AME_RST_SCAN;
                comp_busy_o  <= 1'b1;
                comp_data_o  <= '0;
                comp_shift_o <= '0;
                comp_zero_o  <= 1'b0;
            end else if (scan_end) begin
                state        <= AME_RST_IDLE;
                comp_busy_o  <= 1'b0;
                comp_done_o  <= 1'b1;
                comp_data_o  <= vld ? res : '0;
                comp_shift_o <= vld ? hit_shift : '0;
                comp_zero_o  <= !vld;
            end else if (state == AME_RST_SCAN) begin
                grp <= grp - GRP_W'(1);
            end
        end
    end

`ifdef AME_NUM_RESTORE_ONEHOT_CHK_EN
    logic err_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q      <= 1'b0;
            comp_err_o <= 1'b0;
        end else if (accept) begin
            err_q      <= |(comp_data_i & (comp_data_i - COMP_DATA_BITS'(1)));
            comp_err_o <= 1'b0;
        end else if (scan_end) begin
            comp_err_o <= err_q;
        end
    end
`else
    assign comp_err_o = 1'b0;
`endif
endmodule
